// File: rtl/sound_sequencer.sv
// Event-driven melody sequencer: plays short fixed tunes for eat/start/die
// events with per-note on/gap timing and DIE > START > EAT pre-emption.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ev_eat/start/die    - single-cycle event pulses
//   mute                - level, gates note_on only
//   note_freq[11:0]     - current note frequency in Hz (0 when silent)
//   note_on             - high while a note sounds (registered)
//   busy                - high while a melody is in progress
//   done                - one-cycle pulse on natural melody completion
module sound_sequencer #(
    parameter int NOTE_TICKS = 12500000,
    parameter int GAP_TICKS  = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_eat,
    input  logic        ev_start,
    input  logic        ev_die,
    input  logic        mute,
    output logic [11:0] note_freq,
    output logic        note_on,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Melody ids double as priority levels.
    localparam logic [1:0] M_NONE  = 2'd0;
    localparam logic [1:0] M_EAT   = 2'd1;
    localparam logic [1:0] M_START = 2'd2;
    localparam logic [1:0] M_DIE   = 2'd3;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

    function automatic logic [11:0] freq_of(logic [1:0] m, logic [1:0] i);
        case ({m, i})
            {M_EAT,   2'd0}: freq_of = 12'd880;
            {M_EAT,   2'd1}: freq_of = 12'd1320;
            {M_START, 2'd0}: freq_of = 12'd523;
            {M_START, 2'd1}: freq_of = 12'd659;
            {M_START, 2'd2}: freq_of = 12'd784;
            {M_DIE,   2'd0}: freq_of = 12'd784;
            {M_DIE,   2'd1}: freq_of = 12'd659;
            {M_DIE,   2'd2}: freq_of = 12'd523;
            {M_DIE,   2'd3}: freq_of = 12'd392;
            default:         freq_of = 12'd0;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(logic [1:0] m);
        case (m)
            M_EAT:   last_idx = 2'd1;
            M_START: last_idx = 2'd2;
            M_DIE:   last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

    state_t      state, state_n;
    logic [31:0] tick, tick_n;
    logic [1:0]  idx, idx_n;
    logic [1:0]  mel, mel_n;
    // Set when a pre-empting event forced a gap: the gap end must start
    // note 0 of the new melody rather than advance the index.
    logic        hold, hold_n;
    logic        done_n;
    logic [1:0]  ev_pri;
    logic        accept;
    logic [11:0] freq_n;
    logic        on_n;

    always_comb begin
        ev_pri = ev_die   ? M_DIE   :
                 ev_start ? M_START :
                 ev_eat   ? M_EAT   : M_NONE;
        accept = (ev_pri != M_NONE) &&
                 ((state == IDLE) || (ev_pri >= mel));
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        idx_n   = idx;
        mel_n   = mel;
        hold_n  = hold;
        done_n  = 1'b0;
        if (accept) begin
            mel_n  = ev_pri;
            idx_n  = 2'd0;
            tick_n = 32'd0;
            if (state == NOTE) begin
                state_n = GAP;
                hold_n  = 1'b1;
            end else begin
                state_n = NOTE;
                hold_n  = 1'b0;
            end
        end else begin
            case (state)
                NOTE: begin
                    if (tick == NOTE_LAST) begin
                        state_n = GAP;
                        tick_n  = 32'd0;
                    end else begin
                        tick_n = tick + 32'd1;
                    end
                end
                GAP: begin
                    if (tick == GAP_LAST) begin
                        tick_n = 32'd0;
                        if (hold) begin
                            state_n = NOTE;
                            hold_n  = 1'b0;
                        end else if (idx == last_idx(mel)) begin
                            state_n = IDLE;
                            idx_n   = 2'd0;
                            mel_n   = M_NONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = NOTE;
                            idx_n   = idx + 2'd1;
                        end
                    end else begin
                        tick_n = tick + 32'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        freq_n = (state_n == NOTE) ? freq_of(mel_n, idx_n) : 12'd0;
        on_n   = (state_n == NOTE) && !mute;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= 32'd0;
            idx       <= 2'd0;
            mel       <= M_NONE;
            hold      <= 1'b0;
            note_freq <= 12'd0;
            note_on   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            idx       <= idx_n;
            mel       <= mel_n;
            hold      <= hold_n;
            note_freq <= freq_n;
            note_on   <= on_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed vector bench for sound_sequencer (NOTE_TICKS=4, GAP_TICKS=2).
// Row k drives inputs sampled at edge k and expects outputs of cycle k+1.
module tb_sound_sequencer;

    localparam int NT = 4;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ev_eat = 1'b0;
    logic        ev_start = 1'b0;
    logic        ev_die = 1'b0;
    logic        mute = 1'b0;
    logic [11:0] note_freq;
    logic        note_on;
    logic        busy;
    logic        done;

    sound_sequencer #(
        .NOTE_TICKS(NT),
        .GAP_TICKS (GT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ev_eat   (ev_eat),
        .ev_start (ev_start),
        .ev_die   (ev_die),
        .mute     (mute),
        .note_freq(note_freq),
        .note_on  (note_on),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        eat, start, die, mute, rst;
        logic [11:0] freq;
        logic        on, busy, done;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    logic pe = 1'b0, ps = 1'b0, pd = 1'b0, pr = 1'b0, m = 1'b0;

    task automatic chk(string nm, int row, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d want %0d", nm, row, act, exp);
        end
    endtask

    task automatic put(logic [11:0] f, logic o, logic b, logic d);
        vec_t v;
        v.eat = pe; v.start = ps; v.die = pd; v.mute = m; v.rst = pr;
        v.freq = f; v.on = o; v.busy = b; v.done = d;
        vecs.push_back(v);
        pe = 1'b0; ps = 1'b0; pd = 1'b0; pr = 1'b0;
    endtask

    task automatic note(logic [11:0] f, int n);
        repeat (n) put(f, !m, 1'b1, 1'b0);
    endtask

    task automatic gapr(int n);
        repeat (n) put(12'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) put(12'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fin();
        put(12'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic die_tail();
        gapr(GT); note(12'd659, NT);
        gapr(GT); note(12'd523, NT);
        gapr(GT); note(12'd392, NT);
        gapr(GT); fin();
    endtask

    initial begin
        int n;
        // reset, including reset beating a same-cycle event
        pr = 1; idle(1);
        pr = 1; pe = 1; idle(1);
        idle(1);
        // EAT melody
        pe = 1; note(12'd880, NT); gapr(GT);
        note(12'd1320, NT); gapr(GT); fin();
        // all three events at once: DIE wins, done in cycle 25
        pe = 1; ps = 1; pd = 1; note(12'd784, NT); die_tail();
        // EAT during DIE ignored
        pd = 1; note(12'd784, 3); pe = 1; note(12'd784, 1); die_tail();
        // DIE pre-empts EAT during NOTE: forced gap first
        pe = 1; note(12'd880, 2); pd = 1; gapr(GT);
        note(12'd784, NT); die_tail();
        // muted START
        m = 1; idle(1);
        ps = 1; note(12'd523, NT); gapr(GT);
        note(12'd659, NT); gapr(GT);
        note(12'd784, NT); gapr(GT); fin();
        m = 0; idle(1);
        // reset mid EAT, then EAT again at edge 9
        pe = 1; note(12'd880, NT); gapr(1);
        pr = 1; idle(3);
        pe = 1; note(12'd880, NT); gapr(GT);
        note(12'd1320, NT); gapr(GT); fin();
        // equal-priority restart during GAP: new note at once
        pe = 1; note(12'd880, NT); gapr(1);
        pe = 1; note(12'd880, NT); gapr(GT);
        note(12'd1320, NT); gapr(GT); fin();
        // START pre-empts EAT during its GAP
        pe = 1; note(12'd880, NT); gapr(1);
        ps = 1; note(12'd523, NT); gapr(GT);
        note(12'd659, NT); gapr(GT);
        note(12'd784, NT); gapr(GT); fin();

        foreach (vecs[i]) begin
            ev_eat   = vecs[i].eat;
            ev_start = vecs[i].start;
            ev_die   = vecs[i].die;
            mute     = vecs[i].mute;
            rst      = vecs[i].rst;
            @(posedge clk);
            #1;
            chk("note_freq", i, int'(note_freq), int'(vecs[i].freq));
            chk("note_on",   i, int'(note_on),   int'(vecs[i].on));
            chk("busy",      i, int'(busy),      int'(vecs[i].busy));
            chk("done",      i, int'(done),      int'(vecs[i].done));
        end
        ev_eat = 0; ev_start = 0; ev_die = 0; mute = 0; rst = 0;

        // START melody done latency with a bounded wait
        ev_start = 1;
        @(posedge clk);
        #1;
        ev_start = 0;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_latency", -1, n, 19);
        chk("busy_at_done", -1, int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
